// File: rtl/sram_pkg.sv
// Shared definitions for the asynchronous SRAM controller.
package sram_pkg;

  localparam int DEF_ADDR_W = 18;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_SETUP = 3'd1,
    W_PULSE = 3'd2,
    W_HOLD  = 3'd3,
    R_SETUP = 3'd4,
    R_WAIT  = 3'd5,
    R_DONE  = 3'd6
  } state_t;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// Loadable down-counter that times the WE/OE active window.
module sram_wait_cnt
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  localparam int CNT_W = clog2(WAIT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  logic [CNT_W-1:0] count;

  // Load one less than the wait so the strobe stays active exactly WAIT_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(WAIT_CYCLES - 1);
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller with valid/ready request side.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire logic [DATA_W-1:0] ram_data,
  output logic              ram_en,
  output logic              ram_oe,
  output logic              ram_we
);

  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("sram_ctrl: WAIT_CYCLES must be at least 1");
  end

  state_t            state;
  state_t            next_state;
  logic              accept;
  logic              load_cnt;
  logic              cnt_done;
  logic              data_drive;
  logic [DATA_W-1:0] wdata_q;
  logic              next_ready;
  logic              next_en;
  logic              next_oe;
  logic              next_we;
  logic              next_drive;
  logic              next_resp;

  sram_wait_cnt #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .load(load_cnt),
    .done(cnt_done)
  );

  // The only driver of the SRAM data bus.
  assign ram_data = data_drive ? wdata_q : 'z;

  // Next-state decode, then strobe values derived from the state being entered.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    load_cnt   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept     = 1'b1;
          next_state = req_we ? W_SETUP : R_SETUP;
        end
      end
      W_SETUP: begin
        load_cnt   = 1'b1;
        next_state = W_PULSE;
      end
      W_PULSE: if (cnt_done) next_state = W_HOLD;
      W_HOLD:  next_state = IDLE;
      R_SETUP: begin
        load_cnt   = 1'b1;
        next_state = R_WAIT;
      end
      R_WAIT:  if (cnt_done) next_state = R_DONE;
      R_DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase

    next_ready = 1'b0;
    next_en    = 1'b1;
    next_oe    = 1'b1;
    next_we    = 1'b1;
    next_drive = 1'b0;
    next_resp  = 1'b0;
    case (next_state)
      IDLE:    next_ready = 1'b1;
      W_SETUP: begin next_en = 1'b0; next_drive = 1'b1; end
      W_PULSE: begin next_en = 1'b0; next_we = 1'b0; next_drive = 1'b1; end
      W_HOLD:  begin next_en = 1'b0; next_drive = 1'b1; next_resp = 1'b1; end
      R_SETUP: begin next_en = 1'b0; next_oe = 1'b0; end
      R_WAIT:  begin next_en = 1'b0; next_oe = 1'b0; end
      R_DONE:  next_resp = 1'b1;
      default: next_ready = 1'b0;
    endcase
  end

  // State, registered strobes, request latches and read-data capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      ram_en     <= 1'b1;
      ram_oe     <= 1'b1;
      ram_we     <= 1'b1;
      data_drive <= 1'b0;
      ram_addr   <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state      <= next_state;
      req_ready  <= next_ready;
      ram_en     <= next_en;
      ram_oe     <= next_oe;
      ram_we     <= next_we;
      data_drive <= next_drive;
      resp_valid <= next_resp;
      if (accept) begin
        ram_addr <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (state == R_WAIT && cnt_done) begin
        resp_rdata <= ram_data;
      end
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl across three parameter sets with a small SRAM model.
module tb_sram_ctrl;

  localparam int W0 = 1;
  localparam int W1 = 3;
  localparam int W2 = 2;

  typedef struct {
    int          inst;
    bit          isRead;
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_we;
  logic [19:0] req_addr [3];
  logic [31:0] req_wdata [3];
  wire  [2:0]  req_ready;
  wire  [2:0]  resp_valid;
  wire  [2:0]  ram_en;
  wire  [2:0]  ram_oe;
  wire  [2:0]  ram_we;
  wire  [15:0] rdata0, rdata1;
  wire  [31:0] rdata2;
  wire  [17:0] addr0, addr1;
  wire  [19:0] addr2;
  wire  [15:0] bus0, bus1;
  wire  [31:0] bus2;

  logic [31:0] mem [int];
  logic [31:0] rdVal [3];
  logic [31:0] lastRead [3];
  int          weLow [3];
  int          oeLow [3];
  bit          weWasLow [3];
  exp_t        sb [$];
  exp_t        monEntry;
  logic [31:0] monBus;
  int          cyc;
  int          errors;
  int          checks;
  int          s0;
  int          s1;

  sram_ctrl #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0][17:0]), .req_wdata(req_wdata[0][15:0]),
    .resp_valid(resp_valid[0]), .resp_rdata(rdata0), .ram_addr(addr0), .ram_data(bus0),
    .ram_en(ram_en[0]), .ram_oe(ram_oe[0]), .ram_we(ram_we[0])
  );

  sram_ctrl #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1][17:0]), .req_wdata(req_wdata[1][15:0]),
    .resp_valid(resp_valid[1]), .resp_rdata(rdata1), .ram_addr(addr1), .ram_data(bus1),
    .ram_en(ram_en[1]), .ram_oe(ram_oe[1]), .ram_we(ram_we[1])
  );

  sram_ctrl #(.ADDR_W(20), .DATA_W(32), .WAIT_CYCLES(W2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .resp_valid(resp_valid[2]), .resp_rdata(rdata2), .ram_addr(addr2), .ram_data(bus2),
    .ram_en(ram_en[2]), .ram_oe(ram_oe[2]), .ram_we(ram_we[2])
  );

  // SRAM chips: drive stored data whenever chip and output enables are both low.
  assign bus0 = (!ram_en[0] && !ram_oe[0]) ? rdVal[0][15:0] : 'z;
  assign bus1 = (!ram_en[1] && !ram_oe[1]) ? rdVal[1][15:0] : 'z;
  assign bus2 = (!ram_en[2] && !ram_oe[2]) ? rdVal[2] : 'z;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count used to time responses against the accept edge.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int waitOf(input int i);
    case (i)
      0:       return W0;
      1:       return W1;
      default: return W2;
    endcase
  endfunction

  function automatic logic [31:0] getAddr(input int i);
    case (i)
      0:       return {14'h0, addr0};
      1:       return {14'h0, addr1};
      default: return {12'h0, addr2};
    endcase
  endfunction

  function automatic logic [31:0] getRdata(input int i);
    case (i)
      0:       return {16'h0, rdata0};
      1:       return {16'h0, rdata1};
      default: return rdata2;
    endcase
  endfunction

  function automatic logic [31:0] getBus(input int i);
    case (i)
      0:       return {16'h0, bus0};
      1:       return {16'h0, bus1};
      default: return bus2;
    endcase
  endfunction

  function automatic logic busDriven(input int i);
    case (i)
      0:       return dut0.data_drive;
      1:       return dut1.data_drive;
      default: return dut2.data_drive;
    endcase
  endfunction

  function automatic int key(input int i, input logic [31:0] a);
    return (i << 20) | int'(a[19:0]);
  endfunction

  function automatic logic [31:0] memRead(input int k);
    if (mem.exists(k)) return mem[k];
    return 32'h0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks = checks + 1;
    if (got !== expv) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, expv, cyc);
    end
  endtask

  task automatic applyStimulus(input int sel, input bit we, input logic [31:0] addr,
                               input logic [31:0] data, input bit track, output int start);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    req_valid[sel] = 1'b1;
    req_we[sel]    = we;
    req_addr[sel]  = addr[19:0];
    req_wdata[sel] = data;
    for (int n = 0; n < 64; n++) begin
      if (req_ready[sel] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) checkOutput("acceptTimeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[sel] = 1'b0;
    start = cyc;
    if (track && ok) begin
      e.inst   = sel;
      e.isRead = !we;
      e.addr   = addr;
      e.data   = data;
      e.due    = cyc + 1 + waitOf(sel);
      sb.push_back(e);
    end
  endtask

  task automatic waitDrain();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && req_ready == 3'b111) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("drainTimeout", 32'd0, 32'd1);
  endtask

  // SRAM model bookkeeping plus per-cycle protocol checks and response scoreboard.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      monBus = getBus(i);
      if (weWasLow[i] && ram_we[i] === 1'b1 && ram_en[i] === 1'b0)
        mem[key(i, getAddr(i))] = monBus;
      weWasLow[i] = (ram_we[i] === 1'b0);
      rdVal[i] = memRead(key(i, getAddr(i)));
      if (req_ready[i] === 1'b1) begin
        weLow[i] = 0;
        oeLow[i] = 0;
      end else begin
        if (ram_we[i] === 1'b0) weLow[i] = weLow[i] + 1;
        if (ram_oe[i] === 1'b0) oeLow[i] = oeLow[i] + 1;
      end
      if (rst === 1'b1) begin
        if (ram_oe[i] === 1'b0) checkOutput("busConflict", {31'b0, busDriven(i)}, 32'd0);
        if (ram_en[i] === 1'b0 && sb.size() > 0 && sb[0].inst == i) begin
          checkOutput("addrStable", getAddr(i), sb[0].addr);
          if (!sb[0].isRead) checkOutput("dataStable", monBus, sb[0].data);
        end
        if (resp_valid[i] === 1'b1) begin
          if (sb.size() == 0) begin
            checkOutput("unexpectedResp", 32'd1, 32'd0);
          end else begin
            monEntry = sb.pop_front();
            checkOutput("respInst", i, monEntry.inst);
            checkOutput("respCycle", cyc, monEntry.due);
            if (monEntry.isRead) begin
              checkOutput("readData", getRdata(i), monEntry.data);
              checkOutput("oeLowCycles", oeLow[i], waitOf(i) + 1);
              checkOutput("weDuringRead", weLow[i], 32'd0);
              lastRead[i] = monEntry.data;
            end else begin
              checkOutput("rdataHeld", getRdata(i), lastRead[i]);
              checkOutput("weLowCycles", weLow[i], waitOf(i));
              checkOutput("oeDuringWrite", oeLow[i], 32'd0);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    rst = 1'b0;
    req_valid = 3'b000;
    req_we = 3'b000;
    for (int i = 0; i < 3; i++) begin
      req_addr[i] = '0;
      req_wdata[i] = '0;
      lastRead[i] = '0;
      rdVal[i] = '0;
    end

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput("rstEn", {31'b0, ram_en[i]}, 32'd1);
      checkOutput("rstOe", {31'b0, ram_oe[i]}, 32'd1);
      checkOutput("rstWe", {31'b0, ram_we[i]}, 32'd1);
      checkOutput("rstBusFree", {31'b0, busDriven(i)}, 32'd0);
      checkOutput("rstReady", {31'b0, req_ready[i]}, 32'd0);
      checkOutput("rstResp", {31'b0, resp_valid[i]}, 32'd0);
      checkOutput("rstAddr", getAddr(i), 32'd0);
      checkOutput("rstRdata", getRdata(i), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) checkOutput("readyAfterRst", {31'b0, req_ready[i]}, 32'd1);

    $display("[TB] single write, WAIT_CYCLES=1");
    applyStimulus(0, 1'b1, 32'h12, 32'hBEEF, 1'b1, s0);
    waitDrain();
    checkOutput("writeCommit", memRead(key(0, 32'h12)), 32'hBEEF);

    $display("[TB] read-back, WAIT_CYCLES=3");
    mem[key(1, 32'h12)] = 32'hBEEF;
    applyStimulus(1, 1'b0, 32'h12, 32'hBEEF, 1'b1, s0);
    waitDrain();

    $display("[TB] back-to-back write then read");
    applyStimulus(0, 1'b1, 32'h1, 32'h1234, 1'b1, s0);
    applyStimulus(0, 1'b0, 32'h1, 32'h1234, 1'b1, s1);
    checkOutput("b2bAcceptGap", s1 - s0, W0 + 3);
    waitDrain();

    $display("[TB] reset during write pulse");
    applyStimulus(0, 1'b1, 32'h40, 32'h5555, 1'b0, s0);
    @(negedge clk);
    checkOutput("midWeLow", {31'b0, ram_we[0]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midRstWe", {31'b0, ram_we[0]}, 32'd1);
    checkOutput("midRstEn", {31'b0, ram_en[0]}, 32'd1);
    checkOutput("midRstBusFree", {31'b0, busDriven(0)}, 32'd0);
    checkOutput("midRstResp", {31'b0, resp_valid[0]}, 32'd0);
    checkOutput("midRstRdata", getRdata(0), 32'd0);
    for (int i = 0; i < 3; i++) lastRead[i] = '0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("midNoWrite", {31'b0, mem.exists(key(0, 32'h40))}, 32'd0);
    checkOutput("midReady", {31'b0, req_ready[0]}, 32'd1);

    $display("[TB] wide instance write and read");
    applyStimulus(2, 1'b1, 32'hFFFFF, 32'hDEADBEEF, 1'b1, s0);
    waitDrain();
    checkOutput("wideCommit", memRead(key(2, 32'hFFFFF)), 32'hDEADBEEF);
    applyStimulus(2, 1'b0, 32'hFFFFF, 32'hDEADBEEF, 1'b1, s0);
    waitDrain();

    repeat (2) @(negedge clk);
    checkOutput("scoreboardEmpty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
